reg_file: RTL and testbench

Integer register file with in-flight write scoreboard for the 5-stage RISC-V pipeline. It receives `wb_data` and the write-enable/destination from the writeback stage, serves two combinational read ports to the decode stage, and tracks pending writes per register so decode can detect RAW hazards. Sits between stage_WB (write side) and stage_ID (read/issue side).

---
 rtl/reg_file_if.sv | 46 ++++
 rtl/reg_file.sv | 127 ++++++++++++
 tb/tb_reg_file.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_if
// Description : Bundle of the read, writeback, issue and flush signals that
//               connect stage_ID / stage_WB (master side) to reg_file (slave).
//   master drives : rs1_addr, rs2_addr, wb_rd_addr, wb_reg_write_en, wb_data,
//                   issue_en, issue_rd, flush
//   master sees   : rs1_data, rs2_data, rs1_busy, rs2_busy, sb_error
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5
);
    // Read / hazard ports (decode side)
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_WIDTH-1:0]  rs1_data;
    logic [REG_WIDTH-1:0]  rs2_data;
    logic                  rs1_busy;
    logic                  rs2_busy;

    // Writeback port
    logic [ADDR_WIDTH-1:0] wb_rd_addr;
    logic                  wb_reg_write_en;
    logic [REG_WIDTH-1:0]  wb_data;

    // Issue tracking and pipeline control
    logic                  issue_en;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  flush;
    logic                  sb_error;

    modport master (
        output rs1_addr, rs2_addr, wb_rd_addr, wb_reg_write_en, wb_data,
               issue_en, issue_rd, flush,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, sb_error
    );

    modport slave (
        input  rs1_addr, rs2_addr, wb_rd_addr, wb_reg_write_en, wb_data,
               issue_en, issue_rd, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, sb_error
    );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Integer register file for the 5-stage pipeline with two
//               combinational read ports (write-through bypass from the
//               writeback port) and a per-register 2-bit pending-write
//               scoreboard used by decode for RAW hazard detection.
//   clk     : clock, all state updates on the rising edge
//   reset_n : synchronous active-low reset (clears data, counts, error)
//   bus     : reg_file_if.slave - read ports, busy flags, writeback port,
//             issue port, flush, sticky sb_error
//   Interface parameters must match REG_WIDTH / ADDR_WIDTH of this module,
//   and NUM_REGS must equal 2**ADDR_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    reg_file_if.slave   bus
);

    localparam logic [1:0] C_CNT_MAX = 2'd3;

    // Flattened views of per-register state; entry 0 is hardwired to zero.
    logic [NUM_REGS-1:0][REG_WIDTH-1:0] w_regs;
    logic [NUM_REGS-1:0][1:0]           w_cnt;

    // Writes and issues aimed at x0 are ignored entirely.
    logic w_wb_valid;
    logic w_issue_valid;
    logic w_same_reg;
    logic w_overflow;
    logic w_underflow;
    logic r_sb_error;

    assign w_wb_valid    = bus.wb_reg_write_en && (bus.wb_rd_addr != '0);
    assign w_issue_valid = bus.issue_en && (bus.issue_rd != '0);
    // Issue and writeback to the same register cancel: no count change, no error.
    assign w_same_reg    = w_wb_valid && w_issue_valid && (bus.wb_rd_addr == bus.issue_rd);

    assign w_overflow  = w_issue_valid && !w_same_reg && (w_cnt[bus.issue_rd] == C_CNT_MAX);
    assign w_underflow = w_wb_valid && !w_same_reg && (w_cnt[bus.wb_rd_addr] == 2'd0);

    // ------------------------------------------------------------------------
    // Per-register storage and pending-write counter
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign w_regs[i] = '0;
            assign w_cnt[i]  = 2'd0;
        end else begin : g_live
            logic [REG_WIDTH-1:0] r_data;
            logic [1:0]           r_cnt;
            logic                 w_wr;
            logic                 w_inc;

            assign w_wr  = w_wb_valid && (bus.wb_rd_addr == ADDR_WIDTH'(i));
            assign w_inc = w_issue_valid && (bus.issue_rd == ADDR_WIDTH'(i));

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_data <= '0;
                    r_cnt  <= 2'd0;
                end else begin
                    // Data write still lands during a flush.
                    if (w_wr) begin
                        r_data <= bus.wb_data;
                    end
                    // Counter saturates at both ends instead of wrapping.
                    if (bus.flush) begin
                        r_cnt <= 2'd0;
                    end else if (w_inc && !w_wr && (r_cnt != C_CNT_MAX)) begin
                        r_cnt <= r_cnt + 2'd1;
                    end else if (w_wr && !w_inc && (r_cnt != 2'd0)) begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
            end

            assign w_regs[i] = r_data;
            assign w_cnt[i]  = r_cnt;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky scoreboard error; a flushing cycle never raises it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sb_error <= 1'b0;
        end else if (!bus.flush && (w_overflow || w_underflow)) begin
            r_sb_error <= 1'b1;
        end
    end

    assign bus.sb_error = r_sb_error;

    // ------------------------------------------------------------------------
    // Read ports with write-through bypass
    // ------------------------------------------------------------------------
    logic w_byp1;
    logic w_byp2;
    logic w_dec1;
    logic w_dec2;

    assign w_byp1 = bus.wb_reg_write_en && (bus.wb_rd_addr == bus.rs1_addr);
    assign w_byp2 = bus.wb_reg_write_en && (bus.wb_rd_addr == bus.rs2_addr);

    assign bus.rs1_data = (bus.rs1_addr == '0) ? '0 :
                          w_byp1               ? bus.wb_data : w_regs[bus.rs1_addr];
    assign bus.rs2_data = (bus.rs2_addr == '0) ? '0 :
                          w_byp2               ? bus.wb_data : w_regs[bus.rs2_addr];

    // A writeback completing this cycle already retires one pending write,
    // matching the bypassed data the reader sees.
    assign w_dec1 = w_wb_valid && (bus.wb_rd_addr == bus.rs1_addr);
    assign w_dec2 = w_wb_valid && (bus.wb_rd_addr == bus.rs2_addr);

    assign bus.rs1_busy = (bus.rs1_addr != '0) && (w_cnt[bus.rs1_addr] > {1'b0, w_dec1});
    assign bus.rs2_busy = (bus.rs2_addr != '0) && (w_cnt[bus.rs2_addr] > {1'b0, w_dec2});

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Directed scoreboard bench for reg_file. The driver applies
//               one vector per cycle and queues the hand-computed outputs;
//               a monitor pops and compares them at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int RW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    reg_file_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

    reg_file #(.REG_WIDTH(RW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h @%0t", name, field, act, exp, $time);
        end
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents one.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, "rs1_data", bus.rs1_data, e.d1);
                check(e.name, "rs2_data", bus.rs2_data, e.d2);
                check(e.name, "rs1_busy", {31'd0, bus.rs1_busy}, {31'd0, e.b1});
                check(e.name, "rs2_busy", {31'd0, bus.rs2_busy}, {31'd0, e.b2});
                check(e.name, "sb_error", {31'd0, bus.sb_error}, {31'd0, e.err});
            end
        end
    end

    task automatic idle_inputs();
        bus.rs1_addr        = '0;
        bus.rs2_addr        = '0;
        bus.wb_rd_addr      = '0;
        bus.wb_reg_write_en = 1'b0;
        bus.wb_data         = '0;
        bus.issue_en        = 1'b0;
        bus.issue_rd        = '0;
        bus.flush           = 1'b0;
    endtask

    // One cycle: drive vector just after the rising edge, queue expectation.
    task automatic cyc(input string name,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ird, input logic fl,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic eb1, input logic eb2, input logic eerr);
        exp_t e;
        @(posedge clk);
        #1;
        bus.rs1_addr        = a1;
        bus.rs2_addr        = a2;
        bus.wb_reg_write_en = we;
        bus.wb_rd_addr      = wrd;
        bus.wb_data         = wd;
        bus.issue_en        = ie;
        bus.issue_rd        = ird;
        bus.flush           = fl;
        e.name = name; e.d1 = e1; e.d2 = e2; e.b1 = eb1; e.b2 = eb2; e.err = eerr;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Cleared state on every register, both ports.
        for (int i = 1; i < 32; i++) begin
            cyc("reset_read", 5'(i), 5'(32 - i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Write/bypass/x0 discard (x5 issued first so its writeback is legal).
        cyc("x5_issue",   5, 0, 0, 0, 0,            1, 5, 0, 0,            0,            0, 0, 0);
        cyc("x5_bypass",  5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0,            0, 0, 0);
        cyc("x5_stored",  0, 5, 0, 0, 0,            0, 0, 0, 0,            32'hDEADBEEF, 0, 0, 0);
        cyc("x0_write",   0, 5, 1, 0, 32'h1234,     0, 0, 0, 0,            32'hDEADBEEF, 0, 0, 0);
        cyc("x0_read",    0, 0, 0, 0, 0,            0, 0, 0, 0,            0,            0, 0, 0);

        // RAW on x7: busy the cycle after issue until the writeback cycle.
        cyc("x7_issue",   7, 0, 0, 0, 0,            1, 7, 0, 0,            0, 0, 0, 0);
        cyc("x7_busy1",   7, 0, 0, 0, 0,            0, 0, 0, 0,            0, 1, 0, 0);
        cyc("x7_busy2",   7, 0, 0, 0, 0,            0, 0, 0, 0,            0, 1, 0, 0);
        cyc("x7_wb",      7, 0, 1, 7, 32'h77770007, 0, 0, 0, 32'h77770007, 0, 0, 0, 0);
        cyc("x7_after",   7, 0, 0, 0, 0,            0, 0, 0, 32'h77770007, 0, 0, 0, 0);

        // Saturation at 3 and overflow error.
        cyc("x3_iss1",    3, 0, 0, 0, 0,     1, 3, 0, 0,     0, 0, 0, 0);
        cyc("x3_iss2",    3, 0, 0, 0, 0,     1, 3, 0, 0,     0, 1, 0, 0);
        cyc("x3_iss3",    3, 0, 0, 0, 0,     1, 3, 0, 0,     0, 1, 0, 0);
        cyc("x3_iss4",    3, 0, 0, 0, 0,     1, 3, 0, 0,     0, 1, 0, 0);
        cyc("x3_ovf",     3, 0, 0, 0, 0,     0, 0, 0, 0,     0, 1, 0, 1);
        cyc("x3_wb1",     3, 0, 1, 3, 32'h33, 0, 0, 0, 32'h33, 0, 1, 0, 1);
        cyc("x3_wb2",     3, 0, 1, 3, 32'h34, 0, 0, 0, 32'h34, 0, 1, 0, 1);
        cyc("x3_wb3",     3, 0, 1, 3, 32'h35, 0, 0, 0, 32'h35, 0, 0, 0, 1);
        cyc("x3_clear",   3, 0, 0, 0, 0,     0, 0, 0, 32'h35, 0, 0, 0, 1);

        // Mid-sequence reset discards pending counts and data.
        cyc("x12_issue",  12, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 1);
        do_reset();
        cyc("rst_mid",    12, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Simultaneous issue+writeback holds count; underflow raises error.
        cyc("x9_issue",   9, 0, 0, 0, 0,     1, 9, 0, 0,     0,     0, 0, 0);
        cyc("x9_both",    9, 0, 1, 9, 32'h99, 1, 9, 0, 32'h99, 0,     0, 0, 0);
        cyc("x9_held",    9, 0, 0, 0, 0,     0, 0, 0, 32'h99, 0,     1, 0, 0);
        cyc("x10_udf",    9, 9, 1, 10, 32'hA, 0, 0, 0, 32'h99, 32'h99, 1, 1, 0);
        cyc("udf_err",    9, 9, 0, 0, 0,     0, 0, 0, 32'h99, 32'h99, 1, 1, 1);
        cyc("x9_wb",      9, 9, 1, 9, 32'h98, 0, 0, 0, 32'h98, 32'h98, 0, 0, 1);
        cyc("x10_read",  10, 0, 0, 0, 0,     0, 0, 0, 32'hA,  0,     0, 0, 1);

        // Flush clears counts, keeps the same-cycle write, raises no error.
        do_reset();
        cyc("x2_issue",   2, 0, 0, 0, 0,     1, 2, 0, 0,     0,     0, 0, 0);
        cyc("x4_issue",   2, 4, 0, 0, 0,     1, 4, 0, 0,     0,     1, 0, 0);
        cyc("flush_wb",   2, 4, 1, 2, 32'h55, 0, 0, 1, 32'h55, 0,     0, 1, 0);
        cyc("post_flush", 2, 4, 0, 0, 0,     0, 0, 0, 32'h55, 0,     0, 0, 0);
        cyc("flush_udf",  2, 0, 1, 4, 32'h44, 0, 0, 1, 32'h55, 0,     0, 0, 0);
        cyc("flush_noerr",2, 4, 0, 0, 0,     0, 0, 0, 32'h55, 32'h44, 0, 0, 0);

        // Drain the scoreboard with a bounded wait.
        begin
            int budget;
            budget = 10;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (q.size() > 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain: %0d expectations left, required 0", q.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
